// File: rtl/sata_pkg.sv
// SATA transport-side shared definitions: CRC constants, appender state
// type and the single-dword CRC32 step shared by transmit and receive logic.
package sata_pkg;

  localparam logic [31:0] SATA_CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] SATA_CRC_INIT = 32'h52325032;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_CRC  = 1'b1
  } sata_crc_state_e;

  // Serial LFSR unrolled over one dword, bit 31 first, no reflection, no final XOR.
  function automatic logic [31:0] sata_crc32_dword(input logic [31:0] crc,
                                                   input logic [31:0] dat);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ dat[i];
      c  = {c[30:0], 1'b0} ^ (fb ? SATA_CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/sata_fis_crc_appender.sv
// FIS dword pass-through with one registered output stage; appends the SATA
// CRC32 of the frame as a trailing dword flagged with o_eop.
// Optional length limit: define SATA_FIS_LEN_LIMIT_EN to force a frame end
// after MAX_DWORDS accepted words (o_err pulses on that acceptance).
module sata_fis_crc_appender
  import sata_pkg::*;
#(
  parameter int unsigned MAX_DWORDS = 2049
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] i_dat,
  input  logic        i_val,
  input  logic        i_eop,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  input  logic        o_rdy,
  output logic        o_err
);

  // A zero-length limit would make every word a forced end; reject it early.
  if (MAX_DWORDS < 1) begin : g_bad_max_dwords
    $error("MAX_DWORDS must be at least 1");
  end

  sata_crc_state_e state_q;
  logic [31:0]     crc_q;
  logic [31:0]     o_dat_q;
  logic            o_val_q;
  logic            o_eop_q;
  logic            out_free;
  logic            in_xfer;
  logic            len_hit;
  logic            crc_load;

  assign out_free = ~o_val_q | o_rdy;
  assign i_rdy    = (state_q == ST_DATA) & out_free;
  assign in_xfer  = i_val & i_rdy;
  assign crc_load = (state_q == ST_CRC) & out_free;

`ifdef SATA_FIS_LEN_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_DWORDS + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             o_err_q;

  // Word MAX_DWORDS without i_eop closes the frame as if i_eop were set.
  assign len_hit = in_xfer & ~i_eop & (cnt_q == CNT_W'(MAX_DWORDS - 1));

  // Per-frame accepted-word counter and one-cycle forced-end pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      o_err_q <= 1'b0;
    end else begin
      o_err_q <= len_hit;
      if (crc_load)     cnt_q <= '0;
      else if (in_xfer) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_err = o_err_q;
`else
  assign len_hit = 1'b0;
  assign o_err   = 1'b0;
`endif

  // Frame FSM: forward data words, then load the CRC word once the output frees.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DATA;
      crc_q   <= SATA_CRC_INIT;
      o_dat_q <= '0;
      o_val_q <= 1'b0;
      o_eop_q <= 1'b0;
    end else begin
      if (o_val_q && o_rdy) o_val_q <= 1'b0;
      case (state_q)
        ST_DATA: begin
          if (in_xfer) begin
            o_dat_q <= i_dat;
            o_val_q <= 1'b1;
            o_eop_q <= 1'b0;
            crc_q   <= sata_crc32_dword(crc_q, i_dat);
            if (i_eop || len_hit) state_q <= ST_CRC;
          end
        end
        ST_CRC: begin
          if (out_free) begin
            o_dat_q <= crc_q;
            o_val_q <= 1'b1;
            o_eop_q <= 1'b1;
            crc_q   <= SATA_CRC_INIT;
            state_q <= ST_DATA;
          end
        end
        default: state_q <= ST_DATA;
      endcase
    end
  end

  assign o_dat = o_dat_q;
  assign o_val = o_val_q;
  assign o_eop = o_eop_q;

endmodule

// File: tb/tb_sata_fis_crc_appender.sv
// Scoreboard bench for sata_fis_crc_appender: driver feeds a reference model
// that queues expected output words; an independent monitor pops and compares.
module tb_sata_fis_crc_appender;

`ifdef SATA_FIS_LEN_LIMIT_EN
  localparam int LIM = 4;
`else
  localparam int LIM = 0;
`endif
  localparam int unsigned MAXD = (LIM == 0) ? 2049 : LIM;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'h52325032;

  typedef struct packed {
    logic [31:0] dat;
    logic        eop;
  } word_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] i_dat = '0;
  logic        i_val = 1'b0;
  logic        i_eop = 1'b0;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy = 1'b1;
  logic        o_err;

  always #5 clk = ~clk;

  sata_fis_crc_appender #(.MAX_DWORDS(MAXD)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .o_err(o_err)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    pushed = 0;
  int    exp_err = 0;
  int    got_err = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: random 50%, 2: held low
  word_t exp_q[$];
  int    ocyc[$];
  logic [31:0] m_crc = INIT;
  int    m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // CRC as polynomial division: fold the dword into the remainder, then 32 shifts.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int k = 0; k < 32; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  // Reference model: every accepted word echoes; a frame end adds its CRC.
  task automatic model_accept(input word_t w, output bit ended);
    bit forced;
    exp_q.push_back('{dat: w.dat, eop: 1'b0});
    pushed++;
    m_crc = crc_model(m_crc, w.dat);
    m_cnt++;
    forced = (LIM != 0) && (m_cnt == LIM) && !w.eop;
    ended  = w.eop || forced;
    if (ended) begin
      exp_q.push_back('{dat: m_crc, eop: 1'b1});
      pushed++;
      if (forced) exp_err++;
      m_crc = INIT;
      m_cnt = 0;
    end
  endtask

  // Downstream ready pattern, changed just after each falling edge.
  initial forever begin
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       o_rdy = 1'b1;
      1:       o_rdy = 1'($urandom_range(0, 1));
      default: o_rdy = 1'b0;
    endcase
  end

  // Monitor: samples just before each rising edge, pops on every output transfer.
  initial begin : monitor
    logic        stall;
    logic [31:0] sd;
    logic        se;
    word_t       w;
    stall = 1'b0;
    sd = '0;
    se = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!reset_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_val", o_val, 1);
        check("hold_dat", o_dat, sd);
        check("hold_eop", o_eop, se);
      end
      if (o_err) got_err++;
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_out: got %h eop %0b want no output", o_dat, o_eop);
        end else begin
          w = exp_q.pop_front();
          check("out_dat", o_dat, w.dat);
          check("out_eop", o_eop, w.eop);
        end
        ocyc.push_back(cyc);
      end
      stall = o_val && !o_rdy;
      sd = o_dat;
      se = o_eop;
    end
  end

  // Drive a word stream (eop flags embedded); bubble checks only at full throughput.
  task automatic send(input word_t s[$]);
    bit was_end = 0;
    bit e;
    int n;
    foreach (s[k]) begin
      @(negedge clk);
      #2;
      i_val = 1'b1;
      i_dat = s[k].dat;
      i_eop = s[k].eop;
      n = 0;
      while (!i_rdy && n < 200) begin
        @(negedge clk);
        #2;
        n++;
      end
      if (n >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got no i_rdy want i_rdy within 200 cycles");
        i_val = 1'b0;
        return;
      end
      if (was_end && rdy_mode == 0) check("bubble_len", 32'(n), 32'd1);
      @(posedge clk);
      model_accept(s[k], e);
      was_end = e;
    end
    @(negedge clk);
    #2;
    i_val = 1'b0;
    i_eop = 1'b0;
    if (was_end && rdy_mode == 0) begin
      check("rdy_low_after_eop", i_rdy, 0);
      @(negedge clk);
      #2;
      check("rdy_back", i_rdy, 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    i_val = 1'b0;
    i_eop = 1'b0;
    #1;
    check("rst_o_val", o_val, 0);
    check("rst_o_eop", o_eop, 0);
    check("rst_o_dat", o_dat, 0);
    check("rst_i_rdy", i_rdy, 1);
    check("rst_o_err", o_err, 0);
    exp_q.delete();
    m_crc = INIT;
    m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  function automatic word_t mk(input logic [31:0] d, input logic e);
    return '{dat: d, eop: e};
  endfunction

  initial begin : stim
    word_t       f[$];
    word_t       g[$];
    logic [31:0] reg_fis [5];
    int          p0;
    int          len;
    reg_fis = '{32'h00EC8027, 32'hE0000000, 32'h00000000, 32'h00000001, 32'h00000000};

    // Power-on reset values.
    #3;
    check("por_o_val", o_val, 0);
    check("por_i_rdy", i_rdy, 1);
    check("por_o_dat", o_dat, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // Single-dword FIS after an in-flight reset.
    f.delete();
    f.push_back(mk(32'h11111111, 1'b0));
    f.push_back(mk(32'h22222222, 1'b0));
    send(f);
    do_reset();
    f.delete();
    f.push_back(mk(32'h00000027, 1'b1));
    send(f);
    drain();

    // Register FIS at full throughput: outputs on consecutive cycles.
    f.delete();
    for (int k = 0; k < 5; k++) f.push_back(mk(reg_fis[k], k == 4));
    ocyc.delete();
    p0 = pushed;
    send(f);
    drain();
    check("regfis_out_count", 32'(ocyc.size()), 32'(pushed - p0));
    if (ocyc.size() > 0)
      check("regfis_consecutive", 32'(ocyc[ocyc.size()-1] - ocyc[0]), 32'(ocyc.size() - 1));

    // Same frame under random back-pressure.
    rdy_mode = 1;
    send(f);
    drain();

    // Output held low while the frame ends, then released randomly.
    rdy_mode = 2;
    fork
      send(f);
      begin
        repeat (10) @(negedge clk);
        rdy_mode = 1;
      end
    join
    drain();
    rdy_mode = 0;

    // Back-to-back 3-dword frames with no input gap.
    g.delete();
    g.push_back(mk(32'hDEADBEEF, 1'b0));
    g.push_back(mk(32'h01234567, 1'b0));
    g.push_back(mk(32'h89ABCDEF, 1'b1));
    g.push_back(mk(32'hCAFEF00D, 1'b0));
    g.push_back(mk(32'h00000000, 1'b0));
    g.push_back(mk(32'hFFFFFFFF, 1'b1));
    send(g);
    drain();

    // Reset after 2 of 5 words, then the full frame again.
    g.delete();
    g.push_back(f[0]);
    g.push_back(f[1]);
    send(g);
    do_reset();
    send(f);
    drain();

    // Six words with eop only on the last (forced split when the limit is on).
    g.delete();
    for (int k = 0; k < 6; k++) g.push_back(mk($urandom, k == 5));
    send(g);
    drain();

    // Randomized frames, mixed ready patterns, no gaps inside a batch.
    for (int b = 0; b < 6; b++) begin
      rdy_mode = int'($urandom_range(0, 1));
      g.delete();
      for (int fr = 0; fr < 3; fr++) begin
        len = int'($urandom_range(1, 7));
        for (int k = 0; k < len; k++) g.push_back(mk($urandom, k == len - 1));
      end
      send(g);
      drain();
    end
    rdy_mode = 0;

    check("err_pulses", 32'(got_err), 32'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
